// File: rtl/alu_cmd_sequencer.sv
// Purpose: queues ALU commands, drives one at a time onto a combinational alu, returns its registered result.
// Latency: accept edge E0, pop at E1, capture at E2 (rsp_valid high after E2); sustained 1 result per 2 cycles.
// Backpressure: cmd_ready low while the FIFO holds DEPTH entries; rsp_* held stable while rsp_valid && !rsp_ready.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  input  logic [3:0]             cmd_sel,

  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [3:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_carry,

  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_carry,
  output logic [3:0]             rsp_sel,

  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  cmd_t            mem [DEPTH];
  cmd_t            cmd_in;
  cmd_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            push;
  logic            pop;
  logic            fifo_nonempty;
  logic            capture;
  logic            ack;

  // Ready is derived from the registered count only, so a pop in the same
  // cycle never lets an extra command in.
  assign cmd_ready     = (fifo_count < FULL_CNT);
  assign push          = cmd_valid && cmd_ready;
  assign fifo_nonempty = (fifo_count != '0);

  assign cmd_in.a   = cmd_a;
  assign cmd_in.b   = cmd_b;
  assign cmd_in.sel = cmd_sel;
  assign head       = mem[rd_ptr];

  // Command storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle strobes: pop the head, capture the ALU, acknowledge the response.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // The ALU has had a full cycle to settle on the popped operands.
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ack = 1'b1;
          // Chain straight into the next command to keep the 2-cycle cadence.
          if (fifo_nonempty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ALU operand registers; they keep the last popped command while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_a   <= head.a;
      alu_b   <= head.b;
      alu_sel <= head.sel;
    end
  end

  // Response registers; the payload only changes on capture so it stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_sel   <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_carry <= alu_carry;
      rsp_sel   <= alu_sel;
    end else if (ack) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completed-response counter, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (ack) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: an ALU model closes the loop, a queue-based reference
// model predicts every output each cycle, and directed phases pin exact latencies and values.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [3:0]  cmd_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_carry;
  logic [3:0]  rsp_sel;
  logic [2:0]  fifo_count;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_sel    (cmd_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_sel    (rsp_sel),
    .fifo_count (fifo_count),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU model: {carry, result}; carry is the A+B carry for every opcode.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [7:0] r;
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b};
    case (s)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a * b;
      4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[6:0], a[7]};
      4'h7: r = {a[0], a[7:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? 8'h01 : 8'h00;
      default: r = (a == b) ? 8'h01 : 8'h00;
    endcase
    return {t[8], r};
  endfunction

  always_comb {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

  cmd_t        mq[$];     // accepted, not yet issued
  cmd_t        m_alu;     // last command issued to the ALU
  cmd_t        m_in;
  bit          m_busy;    // issued, result not yet presented
  bit          m_rv;      // result presented, awaiting acceptance
  bit          m_take;
  logic [7:0]  m_rd;
  logic        m_rc;
  logic [3:0]  m_rs;
  logic [15:0] m_opc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_alu  = '0;
      m_busy = 1'b0;
      m_rv   = 1'b0;
      m_rd   = 8'h00;
      m_rc   = 1'b0;
      m_rs   = 4'h0;
      m_opc  = 16'h0000;
    end else begin
      m_take    = cmd_valid && (mq.size() < DEPTH);
      m_in.a    = cmd_a;
      m_in.b    = cmd_b;
      m_in.sel  = cmd_sel;
      if (m_rv) begin
        if (rsp_ready) begin
          m_rv  = 1'b0;
          m_opc = m_opc + 16'd1;
          if (mq.size() > 0) begin
            m_alu  = mq.pop_front();
            m_busy = 1'b1;
          end
        end
      end else if (m_busy) begin
        {m_rc, m_rd} = alu_f(m_alu.a, m_alu.b, m_alu.sel);
        m_rs   = m_alu.sel;
        m_rv   = 1'b1;
        m_busy = 1'b0;
      end else if (mq.size() > 0) begin
        m_alu  = mq.pop_front();
        m_busy = 1'b1;
      end
      if (m_take) mq.push_back(m_in);
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc_n = 0;
  bit rec   = 1'b0;
  int hs_t[$];
  int hs_sel[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    chk("fifo_count", {29'd0, fifo_count}, mq.size());
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (mq.size() < DEPTH)});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
    chk("rsp_data", {24'd0, rsp_data}, {24'd0, m_rd});
    chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, m_rc});
    chk("rsp_sel", {28'd0, rsp_sel}, {28'd0, m_rs});
    chk("alu_a", {24'd0, alu_a}, {24'd0, m_alu.a});
    chk("alu_b", {24'd0, alu_b}, {24'd0, m_alu.b});
    chk("alu_sel", {28'd0, alu_sel}, {28'd0, m_alu.sel});
    chk("op_count", {16'd0, op_count}, {16'd0, m_opc});
    if (rec && rsp_valid && rsp_ready) begin
      hs_t.push_back(cyc_n);
      hs_sel.push_back(int'(rsp_sel));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    bit ok;
    ok        = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
    cmd_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = cmd_ready;
      cyc();
    end
    cmd_valid = 1'b0;
    chk("push_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_opc(input logic [15:0] target, input int budget);
    for (int n = 0; n < budget && op_count != target; n++) cyc();
    chk("op_count_reached", {16'd0, op_count}, {16'd0, target});
  endtask

  logic [7:0] held;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) cyc();

    // Reset values
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single op: 0x0D + 0x04 with exact latency
    rsp_ready = 1'b1;
    push(8'h0D, 8'h04, 4'h0);
    chk("single_e0_valid", {31'd0, rsp_valid}, 32'd0);
    cyc();
    chk("single_e1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("single_e1_alu_a", {24'd0, alu_a}, 32'h0D);
    cyc();
    chk("single_e2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_data", {24'd0, rsp_data}, 32'h11);
    chk("single_carry", {31'd0, rsp_carry}, 32'd0);
    chk("single_sel", {28'd0, rsp_sel}, 32'd0);
    cyc();
    chk("single_op_count", {16'd0, op_count}, 32'd1);
    chk("single_valid_clr", {31'd0, rsp_valid}, 32'd0);

    // Carry out: 0xFF + 0x01
    push(8'hFF, 8'h01, 4'h0);
    cyc();
    cyc();
    chk("carry_valid", {31'd0, rsp_valid}, 32'd1);
    chk("carry_data", {24'd0, rsp_data}, 32'h00);
    chk("carry_carry", {31'd0, rsp_carry}, 32'd1);
    cyc();
    chk("carry_op_count", {16'd0, op_count}, 32'd2);

    // Opcode sweep, back-to-back, consumer always ready
    hs_t.delete();
    hs_sel.delete();
    rec = 1'b1;
    for (int s = 0; s < 16; s++) push(8'h0D, 8'h04, 4'(s));
    wait_opc(16'd18, 100);
    rec = 1'b0;
    chk("sweep_count", hs_t.size(), 32'd16);
    for (int i = 1; i < hs_t.size(); i++) chk("sweep_gap", hs_t[i] - hs_t[i-1], 32'd2);
    for (int i = 0; i < hs_sel.size(); i++) chk("sweep_sel_order", hs_sel[i], i);

    // Backpressure and full FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom), 8'($urandom), 4'($urandom));
    chk("full_fifo_count", {29'd0, fifo_count}, 32'd4);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    held      = m_rd;
    cmd_a     = 8'hA5;
    cmd_b     = 8'h5A;
    cmd_sel   = 4'h9;
    cmd_valid = 1'b1;
    repeat (4) begin
      cyc();
      chk("full_hold_ready", {31'd0, cmd_ready}, 32'd0);
      chk("full_hold_count", {29'd0, fifo_count}, 32'd4);
      chk("full_hold_data", {24'd0, rsp_data}, {24'd0, held});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_opc(16'd23, 60);
    cyc();
    chk("drain_fifo_count", {29'd0, fifo_count}, 32'd0);

    // Simultaneous push and pop with two queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'($urandom), 8'($urandom), 4'($urandom));
    chk("pp_pre_count", {29'd0, fifo_count}, 32'd2);
    chk("pp_pre_valid", {31'd0, rsp_valid}, 32'd1);
    cmd_a     = 8'h33;
    cmd_b     = 8'h44;
    cmd_sel   = 4'h2;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("pp_count", {29'd0, fifo_count}, 32'd2);
    chk("pp_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("pp_op_count", {16'd0, op_count}, 32'd24);
    cyc();
    chk("pp_resp_valid", {31'd0, rsp_valid}, 32'd1);
    push(8'($urandom), 8'($urandom), 4'($urandom));
    chk("rst_pre_count", {29'd0, fifo_count}, 32'd3);

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_op_count", {16'd0, op_count}, 32'd0);
    chk("arst_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("arst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("arst_rsp_sel", {28'd0, rsp_sel}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("post_rst_quiet", {31'd0, rsp_valid}, 32'd0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_sel   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) cyc();
    chk("final_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("final_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
